// File: rtl/sdram_read_arbiter.sv
// Two-requester arbiter in front of the SDRAM controller: video row-preload bursts
// (strict priority) and single-word client reads/writes. Optional data-phase timeout: ARB_TIMEOUT_EN.
module sdram_read_arbiter #(
   parameter int TIMEOUT_CYCLES = 255
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        vid_rd_request,
   input  logic [22:0] vid_rd_address,
   input  logic [8:0]  vid_rd_burst_length,
   output logic        vid_rd_available,
   output logic [31:0] vid_rd_data,
   input  logic        cli_request,
   input  logic        cli_write,
   input  logic [22:0] cli_address,
   input  logic [31:0] cli_wdata,
   input  logic [3:0]  cli_wmask,
   output logic        cli_ack,
   output logic [31:0] cli_rdata,
   input  logic        sd_busy,
   output logic        sd_rd_request,
   output logic [22:0] sd_rd_address,
   output logic [8:0]  sd_rd_burst_length,
   input  logic        sd_rd_available,
   input  logic [31:0] sd_rd_data,
   output logic        sd_wr_request,
   output logic [22:0] sd_wr_address,
   output logic [31:0] sd_wr_data,
   output logic [3:0]  sd_wr_mask,
   input  logic        sd_wr_done,
   output logic [1:0]  owner,
   output logic        vid_overrun,
   output logic        timeout_flag
);

   typedef enum logic [2:0] {
      IDLE, VID_ISSUE, VID_READ, CLI_ISSUE, CLI_READ, CLI_WRITE
   } state_t;

   state_t      state;
   logic        vid_pend;
   logic [22:0] pend_addr;
   logic [8:0]  pend_len;
   logic [8:0]  word_cnt;
   logic        vid_busy;
   logic        vid_accept;
   logic        data_phase;
   logic        phase_evt;
   logic        tmo;

   // A new video pulse is only taken when nothing video-related is in flight.
   assign vid_busy   = vid_pend || (state == VID_ISSUE) || (state == VID_READ);
   assign vid_accept = vid_rd_request && !vid_busy;
   assign data_phase = (state == VID_READ) || (state == CLI_READ) || (state == CLI_WRITE);
   assign phase_evt  = (state == CLI_WRITE) ? sd_wr_done : sd_rd_available;

   assign vid_rd_available = sd_rd_available && (state == VID_READ);
   assign vid_rd_data      = sd_rd_data;

`ifdef ARB_TIMEOUT_EN
   localparam int TW = (TIMEOUT_CYCLES < 2) ? 1 : $clog2(TIMEOUT_CYCLES + 1);
   logic [TW-1:0] idle_cnt;

   assign tmo = data_phase && !phase_evt && (idle_cnt == TW'(TIMEOUT_CYCLES - 1));

   always_ff @(posedge clk) begin
      if (reset) begin
         idle_cnt     <= '0;
         timeout_flag <= 1'b0;
      end else if (data_phase && !phase_evt) begin
         if (tmo) begin
            idle_cnt     <= '0;
            timeout_flag <= 1'b1;
         end else begin
            idle_cnt <= idle_cnt + 1'b1;
         end
      end else begin
         idle_cnt <= '0;
      end
   end
`else
   assign tmo          = 1'b0;
   assign timeout_flag = 1'b0;
`endif

   always_ff @(posedge clk) begin
      if (reset) begin
         state              <= IDLE;
         owner              <= 2'd0;
         vid_pend           <= 1'b0;
         pend_addr          <= '0;
         pend_len           <= '0;
         word_cnt           <= '0;
         vid_overrun        <= 1'b0;
         sd_rd_request      <= 1'b0;
         sd_rd_address      <= '0;
         sd_rd_burst_length <= '0;
         sd_wr_request      <= 1'b0;
         sd_wr_address      <= '0;
         sd_wr_data         <= '0;
         sd_wr_mask         <= '0;
         cli_ack            <= 1'b0;
         cli_rdata          <= '0;
      end else begin
         sd_rd_request <= 1'b0;
         sd_wr_request <= 1'b0;
         cli_ack       <= 1'b0;

         if (vid_rd_request && vid_busy)
            vid_overrun <= 1'b1;
         if (vid_accept) begin
            vid_pend  <= 1'b1;
            pend_addr <= vid_rd_address;
            pend_len  <= vid_rd_burst_length;
         end

         case (state)
            IDLE: begin
               // cli_ack high means the client has not yet seen its completion
               if (vid_rd_request || vid_pend) begin
                  state <= VID_ISSUE;
                  owner <= 2'd1;
               end else if (cli_request && !cli_ack) begin
                  state <= CLI_ISSUE;
                  owner <= 2'd2;
               end
            end
            VID_ISSUE: begin
               if (pend_len == 9'd0) begin
                  vid_pend <= 1'b0;
                  state    <= IDLE;
                  owner    <= 2'd0;
               end else if (!sd_busy) begin
                  sd_rd_request      <= 1'b1;
                  sd_rd_address      <= pend_addr;
                  sd_rd_burst_length <= pend_len;
                  vid_pend           <= 1'b0;
                  word_cnt           <= '0;
                  state              <= VID_READ;
               end
            end
            VID_READ: begin
               if (sd_rd_available) begin
                  word_cnt <= word_cnt + 9'd1;
                  if (word_cnt == pend_len - 9'd1) begin
                     state <= IDLE;
                     owner <= 2'd0;
                  end
               end else if (tmo) begin
                  state <= IDLE;
                  owner <= 2'd0;
               end
            end
            CLI_ISSUE: begin
               if (!sd_busy) begin
                  if (cli_write) begin
                     sd_wr_request <= 1'b1;
                     sd_wr_address <= cli_address;
                     sd_wr_data    <= cli_wdata;
                     sd_wr_mask    <= cli_wmask;
                     state         <= CLI_WRITE;
                     owner         <= 2'd3;
                  end else begin
                     sd_rd_request      <= 1'b1;
                     sd_rd_address      <= cli_address;
                     sd_rd_burst_length <= 9'd1;
                     state              <= CLI_READ;
                  end
               end
            end
            CLI_READ: begin
               if (sd_rd_available || tmo) begin
                  cli_rdata <= sd_rd_available ? sd_rd_data : 32'h0;
                  cli_ack   <= 1'b1;
                  state     <= IDLE;
                  owner     <= 2'd0;
               end
            end
            CLI_WRITE: begin
               if (sd_wr_done || tmo) begin
                  cli_ack <= 1'b1;
                  state   <= IDLE;
                  owner   <= 2'd0;
               end
            end
            default: begin
               state <= IDLE;
               owner <= 2'd0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_sdram_read_arbiter.sv
// Randomized bench for sdram_read_arbiter: bench plays the SDRAM controller and both
// requesters, and compares issued commands and responses against transaction-level expectations.
module tb_sdram_read_arbiter;

   logic        clk = 1'b0;
   logic        reset;
   logic        vid_rd_request;
   logic [22:0] vid_rd_address;
   logic [8:0]  vid_rd_burst_length;
   logic        vid_rd_available;
   logic [31:0] vid_rd_data;
   logic        cli_request;
   logic        cli_write;
   logic [22:0] cli_address;
   logic [31:0] cli_wdata;
   logic [3:0]  cli_wmask;
   logic        cli_ack;
   logic [31:0] cli_rdata;
   logic        sd_busy;
   logic        sd_rd_request;
   logic [22:0] sd_rd_address;
   logic [8:0]  sd_rd_burst_length;
   logic        sd_rd_available;
   logic [31:0] sd_rd_data;
   logic        sd_wr_request;
   logic [22:0] sd_wr_address;
   logic [31:0] sd_wr_data;
   logic [3:0]  sd_wr_mask;
   logic        sd_wr_done;
   logic [1:0]  owner;
   logic        vid_overrun;
   logic        timeout_flag;

   always #5 clk = ~clk;

   sdram_read_arbiter dut (
      .clk(clk), .reset(reset),
      .vid_rd_request(vid_rd_request), .vid_rd_address(vid_rd_address),
      .vid_rd_burst_length(vid_rd_burst_length), .vid_rd_available(vid_rd_available),
      .vid_rd_data(vid_rd_data),
      .cli_request(cli_request), .cli_write(cli_write), .cli_address(cli_address),
      .cli_wdata(cli_wdata), .cli_wmask(cli_wmask), .cli_ack(cli_ack), .cli_rdata(cli_rdata),
      .sd_busy(sd_busy), .sd_rd_request(sd_rd_request), .sd_rd_address(sd_rd_address),
      .sd_rd_burst_length(sd_rd_burst_length), .sd_rd_available(sd_rd_available),
      .sd_rd_data(sd_rd_data), .sd_wr_request(sd_wr_request), .sd_wr_address(sd_wr_address),
      .sd_wr_data(sd_wr_data), .sd_wr_mask(sd_wr_mask), .sd_wr_done(sd_wr_done),
      .owner(owner), .vid_overrun(vid_overrun), .timeout_flag(timeout_flag)
   );

   typedef struct packed {
      logic        wr;
      logic [22:0] a;
      logic [8:0]  l;
      logic [31:0] d;
      logic [3:0]  m;
   } cmd_t;

   cmd_t        obs_q[$];
   cmd_t        exp_q[$];
   int          n_chk = 0;
   int          n_pass = 0;
   logic        exp_ovr = 1'b0;
   logic [31:0] last_rdata = 32'h0;

   function automatic cmd_t mk(input logic wr, input logic [22:0] a, input logic [8:0] l,
                               input logic [31:0] d, input logic [3:0] m);
      cmd_t c;
      c.wr = wr; c.a = a; c.l = l; c.d = d; c.m = m;
      return c;
   endfunction

   // Every command the arbiter hands to the SDRAM controller, in issue order.
   always @(negedge clk) begin
      if (!reset) begin
         if (sd_rd_request) obs_q.push_back(mk(1'b0, sd_rd_address, sd_rd_burst_length, 32'h0, 4'h0));
         if (sd_wr_request) obs_q.push_back(mk(1'b1, sd_wr_address, 9'd0, sd_wr_data, sd_wr_mask));
      end
   end

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_chk++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
   endtask

   task automatic step();
      @(posedge clk);
      #2;
   endtask

   task automatic check_cmds(input string tag);
      chk({tag, "_ncmd"}, 64'(obs_q.size()), 64'(exp_q.size()));
      for (int i = 0; i < obs_q.size() && i < exp_q.size(); i++) begin
         chk({tag, "_cmd_hdr"}, {obs_q[i].wr, obs_q[i].a, obs_q[i].l},
             {exp_q[i].wr, exp_q[i].a, exp_q[i].l});
         chk({tag, "_cmd_dat"}, {obs_q[i].d, obs_q[i].m}, {exp_q[i].d, exp_q[i].m});
      end
      obs_q.delete();
      exp_q.delete();
   endtask

   task automatic vid_pulse(input logic [22:0] a, input logic [8:0] l);
      vid_rd_request = 1'b1;
      vid_rd_address = a;
      vid_rd_burst_length = l;
      step();
      vid_rd_request = 1'b0;
   endtask

   // Waits for the burst command, then streams words; a pulse at word ovr_at must be dropped.
   task automatic vid_serve(input int len, input int ovr_at, input int stop_at);
      bit got;
      got = 1'b0;
      for (int t = 0; t < 20 && !got; t++) begin
         step();
         if (sd_rd_request) got = 1'b1;
      end
      chk("vid_cmd_seen", 64'(got), 64'd1);
      chk("vid_owner", 64'(owner), 64'd1);
      for (int i = 0; i < len && i < stop_at; i++) begin
         int gap;
         logic [31:0] d;
         gap = $urandom_range(0, 2);
         d = $urandom();
         repeat (gap) step();
         if (i == ovr_at) begin
            vid_rd_request = 1'b1;
            vid_rd_address = 23'($urandom());
            vid_rd_burst_length = 9'($urandom());
            exp_ovr = 1'b1;
         end
         sd_rd_available = 1'b1;
         sd_rd_data = d;
         #1;
         chk("vid_avail", 64'(vid_rd_available), 64'd1);
         chk("vid_data", 64'(vid_rd_data), 64'(d));
         step();
         sd_rd_available = 1'b0;
         vid_rd_request = 1'b0;
      end
      if (stop_at >= len) chk("vid_done_owner", 64'(owner), 64'd0);
   endtask

   task automatic cli_xact(input logic wr, input logic [22:0] a, input logic [31:0] d,
                           input logic [3:0] m, input int busy_cyc, input int dly);
      bit got;
      logic busy_prev;
      logic [31:0] rd;
      int bleft;
      got = 1'b0;
      bleft = busy_cyc;
      rd = $urandom();
      cli_request = 1'b1;
      cli_write = wr;
      cli_address = a;
      cli_wdata = d;
      cli_wmask = m;
      sd_busy = (bleft > 0);
      exp_q.push_back(wr ? mk(1'b1, a, 9'd0, d, m) : mk(1'b0, a, 9'd1, 32'h0, 4'h0));
      for (int t = 0; t < 40 && !got; t++) begin
         busy_prev = sd_busy;
         step();
         if (sd_rd_request || sd_wr_request) begin
            got = 1'b1;
            chk("busy_gate", 64'(busy_prev), 64'd0);
         end
         if (bleft > 0) bleft--;
         sd_busy = (bleft > 0);
      end
      sd_busy = 1'b0;
      chk("cli_cmd_seen", 64'(got), 64'd1);
      chk("cli_owner", 64'(owner), wr ? 64'd3 : 64'd2);
      repeat (dly) step();
      chk("cli_ack_early", 64'(cli_ack), 64'd0);
      if (wr) begin
         sd_wr_done = 1'b1;
         step();
         sd_wr_done = 1'b0;
      end else begin
         sd_rd_available = 1'b1;
         sd_rd_data = rd;
         #1;
         chk("cli_no_vid_avail", 64'(vid_rd_available), 64'd0);
         step();
         sd_rd_available = 1'b0;
         last_rdata = rd;
      end
      chk("cli_ack", 64'(cli_ack), 64'd1);
      chk("cli_rdata", 64'(cli_rdata), 64'(last_rdata));
      cli_request = 1'b0;
      step();
      chk("cli_ack_pulse", 64'(cli_ack), 64'd0);
      chk("cli_idle_owner", 64'(owner), 64'd0);
      chk("cli_rdata_hold", 64'(cli_rdata), 64'(last_rdata));
   endtask

   task automatic check_all_zero(input string tag);
      chk({tag, "_owner"}, 64'(owner), 64'd0);
      chk({tag, "_sdrd"}, {sd_rd_request, sd_rd_address, sd_rd_burst_length}, 64'd0);
      chk({tag, "_sdwr"}, {sd_wr_request, sd_wr_address, sd_wr_mask}, 64'd0);
      chk({tag, "_wdata"}, 64'(sd_wr_data), 64'd0);
      chk({tag, "_ack"}, {cli_ack, cli_rdata}, 64'd0);
      chk({tag, "_flags"}, {vid_overrun, timeout_flag}, 64'd0);
   endtask

   initial begin
      reset = 1'b1;
      vid_rd_request = 1'b0; vid_rd_address = '0; vid_rd_burst_length = '0;
      cli_request = 1'b0; cli_write = 1'b0; cli_address = '0; cli_wdata = '0; cli_wmask = '0;
      sd_busy = 1'b0; sd_rd_available = 1'b0; sd_rd_data = '0; sd_wr_done = 1'b0;
      repeat (3) step();
      reset = 1'b0;
      step();
      check_all_zero("rst");

      // 80-word preload with a second pulse dropped mid-burst
      vid_pulse(23'h001000, 9'd80);
      exp_q.push_back(mk(1'b0, 23'h001000, 9'd80, 32'h0, 4'h0));
      vid_serve(80, 10, 1000);
      repeat (3) step();
      chk("overrun", 64'(vid_overrun), 64'(exp_ovr));
      check_cmds("burst80");

      // Simultaneous requests: video goes first, client read follows
      cli_request = 1'b1; cli_write = 1'b0; cli_address = 23'h000010;
      vid_pulse(23'h0002A0, 9'd8);
      exp_q.push_back(mk(1'b0, 23'h0002A0, 9'd8, 32'h0, 4'h0));
      vid_serve(8, -1, 1000);
      cli_xact(1'b0, 23'h000010, 32'h0, 4'h0, 0, 1);
      check_cmds("simul");

      cli_xact(1'b1, 23'h000020, 32'hDEADBEEF, 4'hF, 5, 2);
      check_cmds("wr_busy");

      vid_pulse(23'h0055AA, 9'd0);
      chk("len0_owner_issue", 64'(owner), 64'd1);
      step();
      chk("len0_owner_idle", 64'(owner), 64'd0);
      repeat (3) step();
      check_cmds("len0");

      for (int it = 0; it < 30; it++) begin
         int op;
         int len;
         logic [22:0] a;
         op = $urandom_range(0, 2);
         a = 23'($urandom());
         if (op == 0) begin
            len = $urandom_range(0, 6);
            vid_pulse(a, 9'(len));
            if (len == 0) begin
               step();
               chk("rnd_len0_owner", 64'(owner), 64'd0);
            end else begin
               exp_q.push_back(mk(1'b0, a, 9'(len), 32'h0, 4'h0));
               vid_serve(len, -1, 1000);
            end
         end else begin
            cli_xact(op == 2, a, $urandom(), 4'($urandom()), $urandom_range(0, 3), $urandom_range(0, 3));
         end
         check_cmds("rnd");
      end
      chk("overrun_sticky", 64'(vid_overrun), 64'(exp_ovr));

`ifdef ARB_TIMEOUT_EN
      begin
         bit acked;
         acked = 1'b0;
         cli_request = 1'b1; cli_write = 1'b0; cli_address = 23'h000777;
         exp_q.push_back(mk(1'b0, 23'h000777, 9'd1, 32'h0, 4'h0));
         for (int t = 0; t < 300 && !acked; t++) begin
            step();
            if (cli_ack) acked = 1'b1;
         end
         chk("tmo_ack", 64'(acked), 64'd1);
         chk("tmo_rdata", 64'(cli_rdata), 64'd0);
         chk("tmo_flag", 64'(timeout_flag), 64'd1);
         cli_request = 1'b0;
         last_rdata = 32'h0;
         step();
         check_cmds("tmo");
      end
`endif

      // Reset in the middle of a burst; the remaining words must be ignored
      vid_pulse(23'h003000, 9'd80);
      exp_q.push_back(mk(1'b0, 23'h003000, 9'd80, 32'h0, 4'h0));
      vid_serve(80, 20, 40);
      check_cmds("pre_rst");
      reset = 1'b1;
      step();
      reset = 1'b0;
      exp_ovr = 1'b0;
      last_rdata = 32'h0;
      check_all_zero("midrst");
      for (int i = 0; i < 40; i++) begin
         sd_rd_available = 1'b1;
         sd_rd_data = $urandom();
         #1;
         chk("post_rst_avail", 64'(vid_rd_available), 64'd0);
         step();
         sd_rd_available = 1'b0;
      end
      chk("post_rst_owner", 64'(owner), 64'd0);
      check_cmds("post_rst");
      cli_xact(1'b0, 23'h000040, 32'h0, 4'h0, 1, 0);
      check_cmds("resume");

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
